// File: rtl/wr_ctrl_pkg.sv
// Shared types and default widths for the weight-router sequencer.
package wr_ctrl_pkg;

  localparam int unsigned DefAddrWidth = 8;
  localparam int unsigned DefCntWidth  = 8;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StClear  = 3'd1,
    StLoad   = 3'd2,
    StStream = 3'd3,
    StReuse  = 3'd4,
    StNext   = 3'd5,
    StFin    = 3'd6
  } wr_state_e;

endpackage

// File: rtl/weight_route_ctrl.sv
// Sequencer for one weight_router: walks the filter list, loads each filter's SRAM window,
// streams it to the PE array and replays it once per configured reuse pass.
module weight_route_ctrl
  import wr_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned CNT_WIDTH  = DefCntWidth
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH-1:0] i_filter_stride,
  input  logic [ADDR_WIDTH-1:0] i_addr_offset,
  input  logic [ADDR_WIDTH-1:0] i_route_size,
  input  logic [CNT_WIDTH-1:0]  i_num_filters,
  input  logic [CNT_WIDTH-1:0]  i_num_reuse,
  input  logic                  i_sink_ready,
  input  logic                  i_rtr_ready,
  input  logic                  i_rtr_done,
  output logic                  o_rtr_reg_clear,
  output logic                  o_rtr_en,
  output logic [ADDR_WIDTH-1:0] o_rtr_start_addr,
  output logic [ADDR_WIDTH-1:0] o_rtr_addr_offset,
  output logic [ADDR_WIDTH-1:0] o_rtr_route_size,
  output logic                  o_rtr_pop_en,
  output logic                  o_rtr_reuse_en,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [CNT_WIDTH-1:0]  o_filter_idx,
  output logic [CNT_WIDTH-1:0]  o_reuse_idx
);

  wr_state_e state_q, state_d;

  // Latched job configuration.
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [ADDR_WIDTH-1:0] offset_q, offset_d;
  logic [ADDR_WIDTH-1:0] route_q, route_d;
  logic [CNT_WIDTH-1:0]  num_filters_q, num_filters_d;
  logic [CNT_WIDTH-1:0]  num_reuse_q, num_reuse_d;

  // Progress through the job.
  logic [CNT_WIDTH-1:0]  filter_idx_q, filter_idx_d;
  logic [CNT_WIDTH-1:0]  reuse_idx_q, reuse_idx_d;
  logic [ADDR_WIDTH-1:0] start_addr_q, start_addr_d;
  logic                  load_first_q, load_first_d;

  logic [CNT_WIDTH-1:0]  reuse_last;
  logic [CNT_WIDTH-1:0]  filter_next;

  // A reuse count of zero behaves like a single pass.
  assign reuse_last  = (num_reuse_q == '0) ? '0 : num_reuse_q - CNT_WIDTH'(1);
  assign filter_next = filter_idx_q + CNT_WIDTH'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= StIdle;
      stride_q      <= '0;
      offset_q      <= '0;
      route_q       <= '0;
      num_filters_q <= '0;
      num_reuse_q   <= '0;
      filter_idx_q  <= '0;
      reuse_idx_q   <= '0;
      start_addr_q  <= '0;
      load_first_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      stride_q      <= stride_d;
      offset_q      <= offset_d;
      route_q       <= route_d;
      num_filters_q <= num_filters_d;
      num_reuse_q   <= num_reuse_d;
      filter_idx_q  <= filter_idx_d;
      reuse_idx_q   <= reuse_idx_d;
      start_addr_q  <= start_addr_d;
      load_first_q  <= load_first_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    stride_d      = stride_q;
    offset_d      = offset_q;
    route_d       = route_q;
    num_filters_d = num_filters_q;
    num_reuse_d   = num_reuse_q;
    filter_idx_d  = filter_idx_q;
    reuse_idx_d   = reuse_idx_q;
    start_addr_d  = start_addr_q;
    load_first_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          stride_d      = i_filter_stride;
          offset_d      = i_addr_offset;
          route_d       = i_route_size;
          num_filters_d = i_num_filters;
          num_reuse_d   = i_num_reuse;
          filter_idx_d  = '0;
          reuse_idx_d   = '0;
          start_addr_d  = i_base_addr;
          state_d       = (i_num_filters == '0) ? StFin : StClear;
        end
      end
      StClear: begin
        state_d      = StLoad;
        load_first_d = 1'b1;
      end
      StLoad: begin
        // Router status right after a clear still reflects the previous filter.
        if (!load_first_q && i_rtr_ready) begin
          state_d = StStream;
        end
      end
      StStream: begin
        if (i_rtr_done) begin
          state_d = (reuse_idx_q < reuse_last) ? StReuse : StNext;
        end
      end
      StReuse: begin
        reuse_idx_d = reuse_idx_q + CNT_WIDTH'(1);
        state_d     = StStream;
      end
      StNext: begin
        filter_idx_d = filter_next;
        reuse_idx_d  = '0;
        start_addr_d = start_addr_q + stride_q;
        state_d      = (filter_next == num_filters_q) ? StFin : StClear;
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    o_rtr_reg_clear = 1'b0;
    o_rtr_en        = 1'b0;
    o_rtr_pop_en    = 1'b0;
    o_rtr_reuse_en  = 1'b0;
    o_done          = 1'b0;

    unique case (state_q)
      StClear:  o_rtr_reg_clear = 1'b1;
      StLoad:   o_rtr_en        = 1'b1;
      // A finished pass must not pop, even if the sink is ready.
      StStream: o_rtr_pop_en    = i_sink_ready & ~i_rtr_done;
      StReuse:  o_rtr_reuse_en  = 1'b1;
      StFin:    o_done          = 1'b1;
      default:  ;
    endcase
  end

  assign o_busy            = (state_q != StIdle);
  assign o_rtr_start_addr  = start_addr_q;
  assign o_rtr_addr_offset = offset_q;
  assign o_rtr_route_size  = route_q;
  assign o_filter_idx      = filter_idx_q;
  assign o_reuse_idx       = reuse_idx_q;

endmodule

// File: doc/weight_route_ctrl.md
Name: weight_route_ctrl

Overview:
- Sequencer for the weight router.
- Walks a list of filters. For each filter it clears the router, programs its SRAM window, and waits until the FIFO is loaded.
- Streams the weights into the PE array under a downstream ready signal, then replays the same filter via reuse for a configured number of output positions before moving on.
- Sits between the layer-level controller (start/done) and one weight_router instance.

Parameters:
- ADDR_WIDTH, 8, weight SRAM address width; must match the router.
- CNT_WIDTH, 8, width of the filter and reuse counters.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  one-cycle pulse; latches config and begins a job
- i_base_addr  in  ADDR_WIDTH  SRAM word address of filter 0
- i_filter_stride  in  ADDR_WIDTH  SRAM words between consecutive filters
- i_addr_offset  in  ADDR_WIDTH  last word index within a filter (words-1)
- i_route_size  in  ADDR_WIDTH  weights popped per pass
- i_num_filters  in  CNT_WIDTH  filters in the job
- i_num_reuse  in  CNT_WIDTH  passes per filter; 0 is treated as 1
- i_sink_ready  in  1  PE array accepts a weight this cycle
- i_rtr_ready  in  1  router o_ready
- i_rtr_done  in  1  router o_done
- o_rtr_reg_clear  out  1  router i_reg_clear
- o_rtr_en  out  1  router i_en
- o_rtr_start_addr  out  ADDR_WIDTH  router i_start_addr
- o_rtr_addr_offset  out  ADDR_WIDTH  router i_addr_offset
- o_rtr_route_size  out  ADDR_WIDTH  router i_route_size
- o_rtr_pop_en  out  1  router i_pop_en
- o_rtr_reuse_en  out  1  router i_reuse_en
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse at job end
- o_filter_idx  out  CNT_WIDTH  current filter index
- o_reuse_idx  out  CNT_WIDTH  current pass index

Behaviour:
- Reset (i_rst high at a clock edge):
  - State goes to IDLE.
  - All outputs and counters go to 0.
  - Reset has priority over every other input, including mid-job; no o_done is emitted for an aborted job.
- Config capture:
  - Config is latched only on i_start while in IDLE.
  - i_start in any other state is ignored.
  - Router address/size outputs are driven from the latched registers and stay stable for the whole job.
- States:
  - IDLE: on i_start, go to CLEAR with filter_idx=0, reuse_idx=0, start_addr=base. If i_num_filters==0, go directly to FIN.
  - CLEAR: o_rtr_reg_clear=1 for exactly one cycle, then LOAD.
  - LOAD:
    - o_rtr_en=1 every cycle.
    - i_rtr_ready is ignored during the first cycle of LOAD, because the router status is stale after a clear.
    - Afterwards, i_rtr_ready=1 moves to STREAM, and o_rtr_en drops in that same transition.
  - STREAM:
    - o_rtr_pop_en = i_sink_ready, combinationally; the PE array throttles the stream cycle by cycle.
    - On i_rtr_done=1, pop_en is forced to 0. If reuse_idx < max(i_num_reuse,1)-1, go to REUSE; otherwise go to NEXT.
  - REUSE: o_rtr_reuse_en=1 for one cycle, reuse_idx+1, then STREAM.
  - NEXT:
    - filter_idx+1, reuse_idx=0, start_addr += filter_stride.
    - The add wraps modulo 2^ADDR_WIDTH.
    - If the new filter_idx == i_num_filters, go to FIN; else go to CLEAR.
  - FIN: o_done=1 for one cycle, then IDLE.
- Single-driver rule: at most one of reg_clear, en, pop_en and reuse_en is high in any cycle.
- Latency:
  - From i_start to the first o_rtr_en is 2 cycles.
  - Per-filter overhead outside streaming is 4 cycles: CLEAR, the LOAD blind cycle, NEXT, and the STREAM entry.
- Simultaneous events: i_rtr_done and i_sink_ready in the same cycle means done wins and no pop is issued.
- Counter width: counters saturate logic is not provided. i_num_filters and i_num_reuse up to 2^CNT_WIDTH-1 are supported.

Decomposition:
- Package wr_ctrl_pkg holds the state enum typedef (IDLE, CLEAR, LOAD, STREAM, REUSE, NEXT, FIN) and the default width constants.
- No sub-module is required. The address accumulator stays inline.
- The testbench instantiates the block with a real weight_router to form the integration bench.

Test Plan:
- Reset mid-STREAM (i_rst during filter 1) -> next cycle IDLE, all outputs 0, no o_done.
- Single filter, reuse=1: base=0x10, offset=1, route=9, sink always ready -> one reg_clear, en until ready, 9 pop cycles, done then FIN, o_done pulse, start_addr stays 0x10.
- Filters=3, stride=2, base=0xFE -> start_addr sequence 0xFE, 0x00, 0x02 (wrap); three reg_clear pulses; o_done after the third filter.
- Reuse=4 -> three reuse_en pulses per filter, reuse_idx steps 0..3, and no reg_clear between passes.
- Sink backpressure: i_sink_ready toggles 1,0,1,0 -> pop_en mirrors it exactly; the pass takes 2x route_size cycles.
- num_filters=0 -> IDLE, FIN, IDLE with o_done after 1 cycle, no router strobes. i_start while busy is ignored and the latched config is unchanged.
